// File: rtl/tx_fsm.sv
// Transmit TLP framer: packs a 3DW/4DW header and a DW payload stream into 64-bit AXI4-Stream beats.
// Build option TX_PKT_CNT_EN adds tx_pkt_count, a wrapping count of TLPs sent.
module tx_fsm #(
    parameter int keep_width = 8
) (
    input  logic                  tx_clk,
    input  logic                  tx_reset_n,
    input  logic                  hdr_valid,
    output logic                  hdr_ready,
    input  logic [127:0]          hdr_data,
    input  logic                  pld_valid,
    output logic                  pld_ready,
    input  logic [31:0]           pld_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [63:0]           tx_data,
    output logic [keep_width-1:0] tx_keep,
    output logic                  tx_last,
    output logic                  busy
`ifdef TX_PKT_CNT_EN
    ,
    output logic [15:0]           tx_pkt_count
`endif
);

    localparam logic [keep_width-1:0] keep_full = {keep_width{1'b1}};
    localparam logic [keep_width-1:0] keep_half = {{(keep_width/2){1'b0}}, {(keep_width/2){1'b1}}};

    typedef enum logic [2:0] {IDLE, H1, H2, DATA_LO, DATA_HI, DATA_LAST} state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [127:0]  hdr_reg;
    logic [10:0]   rem_reg;
    logic [31:0]   lo_reg;
    logic          has_data;
    logic          is_4dw;
    logic          rem_one;
    logic          hdr_fire;
    logic          pld_fire;
    logic          tx_fire;

    // fmt[1] = payload present, fmt[0] = 4DW header
    assign has_data = hdr_reg[30];
    assign is_4dw   = hdr_reg[29];
    assign rem_one  = (rem_reg == 11'd1);
    assign hdr_fire = hdr_valid && hdr_ready;
    assign pld_fire = pld_valid && pld_ready;
    assign tx_fire  = tx_valid && tx_ready;

    always_ff @(posedge tx_clk or negedge tx_reset_n) begin
        if (!tx_reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_reset_n) begin
        if (!tx_reset_n) begin
            hdr_reg <= '0;
            rem_reg <= '0;
            lo_reg  <= '0;
        end else begin
            if (hdr_fire) begin
                hdr_reg <= hdr_data;
                rem_reg <= (hdr_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, hdr_data[9:0]};
            end
            if (pld_fire) begin
                rem_reg <= rem_reg - 11'd1;
                if (state_reg == DATA_LO) begin
                    lo_reg <= pld_data;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (hdr_fire) state_next = H1;
            end
            H1: begin
                if (tx_fire) state_next = H2;
            end
            H2: begin
                if (tx_fire) begin
                    if (!has_data)   state_next = IDLE;
                    else if (is_4dw) state_next = DATA_LO;
                    else             state_next = rem_one ? IDLE : DATA_LO;
                end
            end
            DATA_LO: begin
                if (pld_fire) state_next = rem_one ? DATA_LAST : DATA_HI;
            end
            DATA_HI: begin
                if (tx_fire) state_next = rem_one ? IDLE : DATA_LO;
            end
            DATA_LAST: begin
                if (tx_fire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // In H2 (3DW write) and DATA_HI the beat carries the live payload DW, so the
    // payload is consumed exactly when the beat is.
    always_comb begin
        hdr_ready = 1'b0;
        pld_ready = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_keep   = '0;
        tx_last   = 1'b0;
        busy      = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                hdr_ready = 1'b1;
            end
            H1: begin
                tx_valid = 1'b1;
                tx_data  = hdr_reg[63:0];
                tx_keep  = keep_full;
            end
            H2: begin
                if (is_4dw) begin
                    tx_valid = 1'b1;
                    tx_data  = hdr_reg[127:64];
                    tx_keep  = keep_full;
                    tx_last  = !has_data;
                end else if (!has_data) begin
                    tx_valid = 1'b1;
                    tx_data  = {32'h0, hdr_reg[95:64]};
                    tx_keep  = keep_half;
                    tx_last  = 1'b1;
                end else begin
                    tx_valid  = pld_valid;
                    tx_data   = {pld_data, hdr_reg[95:64]};
                    tx_keep   = keep_full;
                    tx_last   = rem_one;
                    pld_ready = tx_ready;
                end
            end
            DATA_LO: begin
                pld_ready = 1'b1;
            end
            DATA_HI: begin
                tx_valid  = pld_valid;
                tx_data   = {pld_data, lo_reg};
                tx_keep   = keep_full;
                tx_last   = rem_one;
                pld_ready = tx_ready;
            end
            DATA_LAST: begin
                tx_valid = 1'b1;
                tx_data  = {32'h0, lo_reg};
                tx_keep  = keep_half;
                tx_last  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef TX_PKT_CNT_EN
    always_ff @(posedge tx_clk or negedge tx_reset_n) begin
        if (!tx_reset_n) begin
            tx_pkt_count <= '0;
        end else if (tx_fire && tx_last) begin
            tx_pkt_count <= tx_pkt_count + 16'd1;
        end
    end
`endif

endmodule
